// File: rtl/axi4_lite_arbiter_pkg.sv
// axi4_lite_pkg: FSM state encoding, AXI response codes and default widths shared by the arbiter slice
package axi4_lite_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR_DATA, WRESP} arb_state_t;
endpackage

// File: rtl/axi4_lite_arbiter_if.sv
// axi4_lite_if: AXI4-Lite channel bundle with master and slave views
interface axi4_lite_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   ARADDR;
  logic            ARVALID, ARREADY;
  logic [DW-1:0]   RDATA;
  logic [1:0]      RRESP;
  logic            RVALID, RREADY;
  logic [AW-1:0]   AWADDR;
  logic            AWVALID, AWREADY;
  logic [DW-1:0]   WDATA;
  logic [DW/8-1:0] WSTRB;
  logic            WVALID, WREADY;
  logic [1:0]      BRESP;
  logic            BVALID, BREADY;
  modport master (
    output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
  );
  modport slave (
    input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/axi4_lite_arbiter_rr.sv
// rr_arbiter_2: two-way round-robin grant; on a tie the requester not served last wins
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);
  assign gnt = &req ? ~last : req[1];
endmodule

// File: rtl/axi4_lite_arbiter.sv
// axi4_lite_arbiter: shares one AXI4-Lite master port between two requesters, one transaction at a time
// Optional watchdog enabled by defining AXI_ARB_TIMEOUT_EN.
module axi4_lite_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [1:0]                  REQ_VALID,
  input  logic [1:0]                  REQ_WRITE,
  input  logic [2*ADDRESS_WIDTH-1:0]  REQ_ADDR,
  input  logic [2*DATA_WIDTH-1:0]     REQ_WDATA,
  input  logic [2*DATA_WIDTH/8-1:0]   REQ_WSTRB,
  output logic [1:0]                  REQ_READY,
  output logic [1:0]                  RSP_VALID,
  output logic [DATA_WIDTH-1:0]       RSP_RDATA,
  output logic [1:0]                  RSP_RESP,
  output logic                        TIMEOUT_ERR,
  axi4_lite_if.master                 m_axi
);
  arb_state_t state;
  logic last, gnt, owner, aw_done, w_done, aw_hs, w_hs;
  rr_arbiter_2 u_rr (.req(REQ_VALID), .last(last), .gnt(gnt));
  assign REQ_READY = (ARESETN && state == IDLE && REQ_VALID[gnt]) ? 2'b01 << gnt : 2'b00;
  assign aw_hs = m_axi.AWVALID && m_axi.AWREADY;
  assign w_hs  = m_axi.WVALID && m_axi.WREADY;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state         <= IDLE;
      last          <= 1'b1;
      owner         <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi.ARVALID <= 1'b0;
      m_axi.ARADDR  <= '0;
      m_axi.RREADY  <= 1'b0;
      m_axi.AWVALID <= 1'b0;
      m_axi.AWADDR  <= '0;
      m_axi.WVALID  <= 1'b0;
      m_axi.WDATA   <= '0;
      m_axi.WSTRB   <= '0;
      m_axi.BREADY  <= 1'b0;
      RSP_VALID     <= 2'b00;
      RSP_RDATA     <= '0;
      RSP_RESP      <= RESP_OKAY;
    end else begin
      RSP_VALID <= 2'b00;
      case (state)
        IDLE: if (REQ_VALID[gnt]) begin
          last  <= gnt;
          owner <= gnt;
          if (REQ_WRITE[gnt]) begin
            state         <= WADDR_DATA;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi.AWVALID <= 1'b1;
            m_axi.AWADDR  <= REQ_ADDR[gnt*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            m_axi.WVALID  <= 1'b1;
            m_axi.WDATA   <= REQ_WDATA[gnt*DATA_WIDTH +: DATA_WIDTH];
            m_axi.WSTRB   <= REQ_WSTRB[gnt*(DATA_WIDTH/8) +: DATA_WIDTH/8];
          end else begin
            state         <= RADDR;
            m_axi.ARVALID <= 1'b1;
            m_axi.ARADDR  <= REQ_ADDR[gnt*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          end
        end
        RADDR: if (m_axi.ARREADY) begin
          state         <= RDATA;
          m_axi.ARVALID <= 1'b0;
          m_axi.ARADDR  <= '0;
          m_axi.RREADY  <= 1'b1;
        end
        RDATA: if (m_axi.RVALID) begin
          state        <= IDLE;
          m_axi.RREADY <= 1'b0;
          RSP_VALID    <= 2'b01 << owner;
          RSP_RDATA    <= m_axi.RDATA;
          RSP_RESP     <= m_axi.RRESP;
        end
        WADDR_DATA: begin
          if (aw_hs) begin
            m_axi.AWVALID <= 1'b0;
            m_axi.AWADDR  <= '0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi.WVALID <= 1'b0;
            m_axi.WDATA  <= '0;
            m_axi.WSTRB  <= '0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state        <= WRESP;
            m_axi.BREADY <= 1'b1;
          end
        end
        WRESP: if (m_axi.BVALID) begin
          state        <= IDLE;
          m_axi.BREADY <= 1'b0;
          RSP_VALID    <= 2'b01 << owner;
          RSP_RDATA    <= '0;
          RSP_RESP     <= m_axi.BRESP;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  arb_state_t state_d;
  logic [CW-1:0] tmo_cnt, tmo_cur;
  logic tmo_q, busy;
  // tmo_cur counts cycles already spent in the current state, zero on its first cycle
  assign busy        = state != IDLE;
  assign tmo_cur     = state != state_d ? '0 : tmo_cnt;
  assign TIMEOUT_ERR = tmo_q || (busy && tmo_cur == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state_d <= IDLE;
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_d <= state;
      tmo_cnt <= (busy && tmo_cur != CW'(TIMEOUT_CYCLES - 1)) ? tmo_cur + 1'b1 : tmo_cur;
      tmo_q   <= TIMEOUT_ERR;
    end
`else
  assign TIMEOUT_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// tb_axi4_lite_arbiter: scoreboard bench for the two-requester AXI4-Lite arbiter with a latency-programmable slave
`timescale 1ns/1ps
module tb_axi4_lite_arbiter;
  import axi4_lite_pkg::*;
  typedef struct {
    logic [1:0]  who;
    logic [31:0] data;
    logic [1:0]  resp;
    int          cyc;
  } rsp_t;
  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [1:0]  REQ_VALID = '0, REQ_WRITE = '0;
  logic [63:0] REQ_ADDR = '0, REQ_WDATA = '0;
  logic [7:0]  REQ_WSTRB = '0;
  logic [1:0]  REQ_READY, RSP_VALID, RSP_RESP;
  logic [31:0] RSP_RDATA;
  logic        TIMEOUT_ERR;
  rsp_t        sb[$];
  logic [31:0] arq[$], awq[$];
  logic [35:0] wq[$];
  int total = 0, bad = 0, cyc = 0, acc = 0;
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  int ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_resp = '0;
  logic [2:0]  wr_seq [5] = '{3'b110, 3'b010, 3'b010, 3'b010, 3'b001};
  axi4_lite_if #(.AW(32), .DW(32)) bus ();
  axi4_lite_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB), .REQ_READY(REQ_READY),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
    .TIMEOUT_ERR(TIMEOUT_ERR), .m_axi(bus)
  );
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // slave: each READY/VALID rises once its partner has been waiting more than *_wait cycles
  initial begin
    {bus.ARREADY, bus.RVALID, bus.AWREADY, bus.WREADY, bus.BVALID} = '0;
    bus.RDATA = '0;
    bus.RRESP = '0;
    bus.BRESP = '0;
    forever begin
      @(posedge ACLK); #1;
      ar_n = bus.ARVALID ? ar_n + 1 : 0;
      aw_n = bus.AWVALID ? aw_n + 1 : 0;
      w_n  = bus.WVALID  ? w_n + 1  : 0;
      r_n  = bus.RREADY  ? r_n + 1  : 0;
      b_n  = bus.BREADY  ? b_n + 1  : 0;
      bus.ARREADY = ar_n > ar_wait;
      bus.AWREADY = aw_n > aw_wait;
      bus.WREADY  = w_n > w_wait;
      bus.RVALID  = r_n > r_wait;
      bus.RDATA   = bus.RVALID ? s_rdata : '0;
      bus.RRESP   = bus.RVALID ? s_resp : '0;
      bus.BVALID  = b_n > b_wait;
      bus.BRESP   = bus.BVALID ? s_resp : '0;
    end
  end
  initial forever begin
    rsp_t e;
    @(negedge ACLK);
    if (RSP_VALID !== 2'b00) begin
      if (sb.size() == 0) check("rsp_unexpected", RSP_VALID, 0);
      else begin
        e = sb.pop_front();
        check("rsp_owner", RSP_VALID, e.who);
        check("rsp_rdata", RSP_RDATA, e.data);
        check("rsp_resp", RSP_RESP, e.resp);
        if (e.cyc >= 0) check("rsp_cycle", cyc, e.cyc);
      end
    end
    if (bus.ARVALID && bus.ARREADY) begin
      if (arq.size() == 0) check("ar_unexpected", bus.ARADDR, 64'hX);
      else check("araddr", bus.ARADDR, arq.pop_front());
    end
    if (bus.AWVALID && bus.AWREADY) begin
      if (awq.size() == 0) check("aw_unexpected", bus.AWADDR, 64'hX);
      else check("awaddr", bus.AWADDR, awq.pop_front());
    end
    if (bus.WVALID && bus.WREADY) begin
      if (wq.size() == 0) check("w_unexpected", bus.WDATA, 64'hX);
      else check("wstrb_wdata", {bus.WSTRB, bus.WDATA}, wq.pop_front());
    end
  end
  task automatic issue(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int acc_cyc);
    int n = 0;
    REQ_VALID[i] = 1'b1;
    REQ_WRITE[i] = wr;
    REQ_ADDR[i*32 +: 32] = a;
    REQ_WDATA[i*32 +: 32] = d;
    REQ_WSTRB[i*4 +: 4] = s;
    do begin @(negedge ACLK); n++; end while (!REQ_READY[i] && n < 100);
    check("accept", REQ_READY[i], 1);
    acc_cyc = cyc;
    @(posedge ACLK); #1;
    REQ_VALID[i] = 1'b0;
  endtask
  task automatic dual(input bit wr, input logic [31:0] a0, input logic [31:0] a1, input int cnt);
    int got = 0, n = 0;
    REQ_WRITE = {wr, wr};
    REQ_ADDR  = {a1, a0};
    REQ_WDATA = {~a1, ~a0};
    REQ_WSTRB = 8'hFF;
    REQ_VALID = 2'b11;
    while (got < cnt && n < 300) begin
      @(negedge ACLK);
      n++;
      if (REQ_READY != 2'b00) got++;
    end
    check("dual_accepts", got, cnt);
    @(posedge ACLK); #1;
    REQ_VALID = 2'b00;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge ACLK); n++; end
    check("drain", sb.size(), 0);
    @(posedge ACLK); #1;
  endtask
  initial begin
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_valids", {bus.ARVALID, bus.AWVALID, bus.WVALID, bus.RREADY, bus.BREADY}, 0);
    check("rst_addr", {bus.ARADDR, bus.AWADDR}, 0);
    check("rst_wdata", {bus.WSTRB, bus.WDATA}, 0);
    check("rst_req_ready", REQ_READY, 0);
    check("rst_rsp", {RSP_VALID, RSP_RESP, RSP_RDATA}, 0);
    check("rst_timeout", TIMEOUT_ERR, 0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    // zero-wait read by requester 0
    s_rdata = 32'hDEAD_BEEF;
    s_resp = RESP_OKAY;
    arq.push_back(32'h10);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, acc);
    sb.push_back('{2'b01, 32'hDEAD_BEEF, RESP_OKAY, acc + 3});
    drain();
    // write by requester 1 with W delayed and SLVERR response
    w_wait = 3;
    s_resp = RESP_SLVERR;
    awq.push_back(32'h300);
    wq.push_back({4'b0011, 32'hA5A5_0001});
    issue(1, 1'b1, 32'h300, 32'hA5A5_0001, 4'b0011, acc);
    sb.push_back('{2'b10, 32'h0, RESP_SLVERR, acc + 6});
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      check("wr_aw_w_b", {bus.AWVALID, bus.WVALID, bus.BREADY}, wr_seq[k]);
    end
    drain();
    w_wait = 0;
    // both requesters writing continuously must alternate
    s_resp = RESP_OKAY;
    for (int k = 0; k < 3; k++) begin
      awq.push_back(32'h100);
      awq.push_back(32'h200);
      wq.push_back({4'hF, ~32'h100});
      wq.push_back({4'hF, ~32'h200});
      sb.push_back('{2'b01, 32'h0, RESP_OKAY, -1});
      sb.push_back('{2'b10, 32'h0, RESP_OKAY, -1});
    end
    dual(1'b1, 32'h100, 32'h200, 6);
    drain();
    // ARREADY withheld for 5 cycles; request address changed after acceptance
    ar_wait = 5;
    s_rdata = 32'h1234_5678;
    s_resp = RESP_EXOKAY;
    arq.push_back(32'h44);
    issue(0, 1'b0, 32'h44, 32'h0, 4'h0, acc);
    REQ_ADDR[31:0] = 32'hFFFF_FFFC;
    sb.push_back('{2'b01, 32'h1234_5678, RESP_EXOKAY, acc + 8});
    for (int k = 0; k < 6; k++) begin
      @(negedge ACLK);
      check("ar_hold", {bus.ARVALID, bus.ARADDR}, {1'b1, 32'h44});
    end
    drain();
    ar_wait = 0;
    // reset while waiting in RDATA drops the transaction silently
    r_wait = 20;
    arq.push_back(32'h80);
    issue(1, 1'b0, 32'h80, 32'h0, 4'h0, acc);
    @(posedge ACLK); #3;
    check("pre_rst_rready", bus.RREADY, 1);
    ARESETN = 1'b0;
    #1;
    check("mid_rst_out", {bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.BREADY, RSP_VALID, REQ_READY}, 0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    r_wait = 0;
    s_rdata = 32'h0BAD_F00D;
    s_resp = RESP_OKAY;
    arq.push_back(32'h10);
    arq.push_back(32'h20);
    sb.push_back('{2'b01, 32'h0BAD_F00D, RESP_OKAY, -1});
    sb.push_back('{2'b10, 32'h0BAD_F00D, RESP_OKAY, -1});
    dual(1'b0, 32'h10, 32'h20, 2);
    drain();
`ifdef AXI_ARB_TIMEOUT_EN
    b_wait = 10;
    awq.push_back(32'h400);
    wq.push_back({4'hF, 32'h55});
    issue(0, 1'b1, 32'h400, 32'h55, 4'hF, acc);
    sb.push_back('{2'b01, 32'h0, RESP_OKAY, acc + 13});
    repeat (8) @(negedge ACLK);
    check("tmo_before", TIMEOUT_ERR, 0);
    @(negedge ACLK);
    check("tmo_rise", TIMEOUT_ERR, 1);
    drain();
    repeat (3) @(negedge ACLK);
    check("tmo_sticky", TIMEOUT_ERR, 1);
    b_wait = 0;
`else
    check("tmo_tied", TIMEOUT_ERR, 0);
`endif
    check("arq_empty", arq.size() + awq.size() + wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
